// File: rtl/owire_pad_pkg.sv
// Shared op codes, FSM encoding and default bus timing for the single-wire pad master.
package owire_pad_pkg;

  typedef enum logic [1:0] {
    OP_RESET = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_NOP   = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SLOT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DEF_CLKS_PER_US = 50;
  localparam int DEF_RST_LOW_US  = 480;
  localparam int DEF_RST_SMP_US  = 550;
  localparam int DEF_RST_TOT_US  = 960;
  localparam int DEF_SLOT_US     = 70;
  localparam int DEF_WR1_LOW_US  = 6;
  localparam int DEF_WR0_LOW_US  = 60;
  localparam int DEF_RD_LOW_US   = 6;
  localparam int DEF_RD_SMP_US   = 14;

endpackage

// File: rtl/owire_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input, with selectable reset value.
module owire_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/owire_pad_master.sv
// Single-wire bus master: runs one timed reset/write/read slot per accepted command
// and drives the pad buffer open-drain (data tied low, tristate enable toggled).
module owire_pad_master
  import owire_pad_pkg::*;
#(
  parameter int CLKS_PER_US = DEF_CLKS_PER_US,
  parameter int RST_LOW_US  = DEF_RST_LOW_US,
  parameter int RST_SMP_US  = DEF_RST_SMP_US,
  parameter int RST_TOT_US  = DEF_RST_TOT_US,
  parameter int SLOT_US     = DEF_SLOT_US,
  parameter int WR1_LOW_US  = DEF_WR1_LOW_US,
  parameter int WR0_LOW_US  = DEF_WR0_LOW_US,
  parameter int RD_LOW_US   = DEF_RD_LOW_US,
  parameter int RD_SMP_US   = DEF_RD_SMP_US
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_bit,
  output logic       rsp_valid,
  output logic       rsp_bit,
  output logic       busy,
  output logic       PAD_I,
  output logic       PAD_T,
  input  logic       PAD_O
);

  localparam int US_W = $clog2(RST_TOT_US + 1);
  localparam int PS_W = $clog2(CLKS_PER_US);

  typedef logic [US_W-1:0] us_t;
  typedef logic [PS_W-1:0] ps_t;

  localparam us_t RST_LOW = us_t'(RST_LOW_US);
  localparam us_t RST_SMP = us_t'(RST_SMP_US);
  localparam us_t RST_TOT = us_t'(RST_TOT_US);
  localparam us_t SLOT    = us_t'(SLOT_US);
  localparam us_t WR1_LOW = us_t'(WR1_LOW_US);
  localparam us_t WR0_LOW = us_t'(WR0_LOW_US);
  localparam us_t RD_LOW  = us_t'(RD_LOW_US);
  localparam us_t RD_SMP  = us_t'(RD_SMP_US);
  localparam ps_t PS_LAST = ps_t'(CLKS_PER_US - 1);

  if (CLKS_PER_US < 2) begin : g_bad_clks
    $error("owire_pad_master: CLKS_PER_US must be at least 2");
  end
  if (!(RST_LOW_US < RST_SMP_US && RST_SMP_US < RST_TOT_US)) begin : g_bad_rst
    $error("owire_pad_master: reset timing needs low < sample < total");
  end
  if (!(RD_LOW_US < RD_SMP_US && RD_SMP_US < SLOT_US)) begin : g_bad_rd
    $error("owire_pad_master: read timing needs low < sample < slot");
  end
  if (!(WR0_LOW_US < SLOT_US) || !(SLOT_US <= RST_TOT_US)) begin : g_bad_wr
    $error("owire_pad_master: write-0 low time must fit inside the slot");
  end

  state_t state;
  op_t    op_q;
  logic   bit_q;
  ps_t    presc;
  us_t    us_cnt;
  logic   smp_bit;
  logic   pad_sync;

  us_t    low_len;
  us_t    smp_pt;
  us_t    tot_len;
  logic   do_smp;
  logic   presc_wrap;
  us_t    us_nxt;

  owire_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (PAD_O),
    .q     (pad_sync)
  );

  always_comb begin
    low_len = '0;
    smp_pt  = '0;
    tot_len = SLOT;
    do_smp  = 1'b0;
    case (op_q)
      OP_RESET: begin
        low_len = RST_LOW;
        smp_pt  = RST_SMP;
        tot_len = RST_TOT;
        do_smp  = 1'b1;
      end
      OP_WRITE: low_len = bit_q ? WR1_LOW : WR0_LOW;
      OP_READ: begin
        low_len = RD_LOW;
        smp_pt  = RD_SMP;
        do_smp  = 1'b1;
      end
      default: ;
    endcase
    presc_wrap = (presc == PS_LAST);
    us_nxt     = presc_wrap ? us_cnt + 1'b1 : us_cnt;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      op_q      <= OP_NOP;
      bit_q     <= 1'b0;
      presc     <= '0;
      us_cnt    <= '0;
      smp_bit   <= 1'b0;
      PAD_T     <= 1'b1;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_bit   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q      <= op_t'(cmd_op);
            bit_q     <= cmd_bit;
            presc     <= '0;
            us_cnt    <= '0;
            smp_bit   <= 1'b0;
            cmd_ready <= 1'b0;
            if (op_t'(cmd_op) == OP_NOP) begin
              state     <= ST_DONE;
              rsp_valid <= 1'b1;
              rsp_bit   <= 1'b0;
            end else begin
              state <= ST_SLOT;
              PAD_T <= 1'b0;
            end
          end
        end
        ST_SLOT: begin
          if (presc_wrap) begin
            presc  <= '0;
            us_cnt <= us_cnt + 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
          // Presence is an active-low answer, so the reset slot stores the inverted line.
          if (do_smp && us_cnt == smp_pt && presc == '0)
            smp_bit <= (op_q == OP_RESET) ? ~pad_sync : pad_sync;
          if (presc_wrap && us_cnt == tot_len - 1'b1) begin
            state     <= ST_DONE;
            PAD_T     <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_bit   <= smp_bit;
          end else begin
            // Registered enable: decide from the counter value of the coming cycle.
            PAD_T <= !(us_nxt < low_len);
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          rsp_bit   <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          PAD_T     <= 1'b1;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          rsp_bit   <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = ~cmd_ready;
  assign PAD_I = 1'b0;

endmodule

// File: tb/tb_owire_pad_master.sv
// Bench for owire_pad_master at 4 clocks per us: pull-up plus slave pulldown pad model,
// per-cycle comparison against a slot-level model, plus literal per-command expectations.
module tb_owire_pad_master;
  import owire_pad_pkg::*;

  localparam int C = 4;

  logic       clk = 1'b0;
  logic       RST_N = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b11;
  logic       cmd_bit = 1'b0;
  logic       cmd_ready, rsp_valid, rsp_bit, busy, PAD_I, PAD_T, PAD_O;

  owire_pad_master #(.CLKS_PER_US(C)) dut (
    .CLK       (clk),
    .RST_N     (RST_N),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_bit   (cmd_bit),
    .rsp_valid (rsp_valid),
    .rsp_bit   (rsp_bit),
    .busy      (busy),
    .PAD_I     (PAD_I),
    .PAD_T     (PAD_T),
    .PAD_O     (PAD_O)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Slave pulls the line low in a window measured in us from the falling edge of the slot.
  bit   sl_en = 1'b0;
  int   sl_from = 0;
  int   sl_to = 0;
  int   slot_start = 0;
  logic slave_low;
  always @(negedge PAD_T) slot_start = cyc;
  assign slave_low = sl_en && (cyc >= slot_start + sl_from * C) && (cyc < slot_start + sl_to * C);
  assign PAD_O = (PAD_T === 1'b0 || slave_low) ? 1'b0 : 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int slot_us(input logic [1:0] op);
    case (op)
      2'b00:   return DEF_RST_TOT_US;
      2'b11:   return 0;
      default: return DEF_SLOT_US;
    endcase
  endfunction

  function automatic int low_us(input logic [1:0] op, input logic b);
    case (op)
      2'b00:   return DEF_RST_LOW_US;
      2'b01:   return b ? DEF_WR1_LOW_US : DEF_WR0_LOW_US;
      2'b10:   return DEF_RD_LOW_US;
      default: return 0;
    endcase
  endfunction

  function automatic logic pred_bit(input logic [1:0] op, input bit en, input int f, input int t);
    case (op)
      2'b00:   return en && f <= DEF_RST_SMP_US && DEF_RST_SMP_US < t;
      2'b10:   return !(en && f <= DEF_RD_SMP_US && DEF_RD_SMP_US < t);
      default: return 1'b0;
    endcase
  endfunction

  // Slot-level model: one accepted command occupies the cycles after acceptance.
  bit   armed = 1'b0;
  bit   m_act = 1'b0;
  int   m_acc = 0;
  int   m_len = 0;
  int   m_low = 0;
  logic m_bit = 1'b0;

  always @(negedge clk) begin
    if (armed) begin
      logic e_rv, e_pt;
      e_rv = m_act && (cyc == m_acc + m_len + 1);
      e_pt = !(m_act && (cyc - m_acc - 1) < m_low);
      chk("cmd_ready", 32'(cmd_ready), 32'(!m_act));
      chk("busy", 32'(busy), 32'(m_act));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("rsp_bit", 32'(rsp_bit), 32'(e_rv && m_bit));
      chk("PAD_T", 32'(PAD_T), 32'(e_pt));
      chk("PAD_I", 32'(PAD_I), 32'(1'b0));
    end
    if (!RST_N) begin
      m_act = 1'b0;
      armed = 1'b1;
    end else if (armed) begin
      if (!m_act && cmd_valid) begin
        m_act = 1'b1;
        m_acc = cyc;
        m_len = slot_us(cmd_op) * C;
        m_low = low_us(cmd_op, cmd_bit) * C;
        m_bit = pred_bit(cmd_op, sl_en, sl_from, sl_to);
      end else if (m_act && cyc == m_acc + m_len + 1) begin
        m_act = 1'b0;
      end
    end
  end

  task automatic run_cmd(input logic [1:0] op, input logic b, input bit en, input int from,
                         input int to, input bit hold, input int exp_low, input int exp_off,
                         input logic exp_bit, input string tag);
    int n, acc, low, extra, off;
    logic got;
    sl_en = en;
    sl_from = from;
    sl_to = to;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_ready_wait"}, 32'(n < 100), 32'(1'b1));
    cmd_op = op;
    cmd_bit = b;
    cmd_valid = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1;
    if (hold) begin
      cmd_op = ~op;
      cmd_bit = ~b;
    end else begin
      cmd_valid = 1'b0;
    end
    low = 0;
    extra = 0;
    off = -1;
    got = 1'bx;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (PAD_T === 1'b0) low++;
      if (cmd_valid && cmd_ready === 1'b1) extra++;
      if (rsp_valid === 1'b1) begin
        off = cyc - acc;
        got = rsp_bit;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    sl_en = 1'b0;
    chk({tag, "_low_cycles"}, 32'(low), 32'(exp_low));
    chk({tag, "_rsp_offset"}, 32'(off), 32'(exp_off));
    chk({tag, "_rsp_bit"}, 32'(got), 32'(exp_bit));
    chk({tag, "_extra_accepts"}, 32'(extra), 32'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, n;
    repeat (3) @(posedge clk);
    #1;
    RST_N = 1'b1;
    @(negedge clk);
    chk("reset_ready", 32'(cmd_ready), 32'(1'b1));
    chk("reset_pad_t", 32'(PAD_T), 32'(1'b1));

    run_cmd(2'b00, 1'b0, 1'b1, 500, 620, 1'b0, 1920, 3841, 1'b1, "reset_presence");
    run_cmd(2'b00, 1'b0, 1'b0, 0, 0, 1'b0, 1920, 3841, 1'b0, "reset_empty");
    run_cmd(2'b01, 1'b1, 1'b0, 0, 0, 1'b0, 24, 281, 1'b0, "write1");
    run_cmd(2'b01, 1'b0, 1'b0, 0, 0, 1'b0, 240, 281, 1'b0, "write0");
    run_cmd(2'b10, 1'b0, 1'b1, 0, 30, 1'b0, 24, 281, 1'b0, "read_low");
    run_cmd(2'b10, 1'b1, 1'b0, 0, 0, 1'b0, 24, 281, 1'b1, "read_high");
    // slave still low past the slot end must not disturb timing
    run_cmd(2'b10, 1'b0, 1'b1, 0, 75, 1'b0, 24, 281, 1'b0, "read_stretch");

    // Reset asserted in the middle of a reset slot.
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    cmd_op = 2'b00;
    cmd_valid = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    while (cyc < acc + 100) begin
      @(posedge clk);
      #1;
    end
    chk("midrst_low_before", 32'(PAD_T), 32'(1'b0));
    RST_N = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_pad_t", 32'(PAD_T), 32'(1'b1));
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'(1'b0));
    chk("midrst_ready", 32'(cmd_ready), 32'(1'b1));
    RST_N = 1'b1;
    n = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) n++;
    end
    chk("midrst_no_rsp", 32'(n), 32'(0));

    run_cmd(2'b01, 1'b1, 1'b0, 0, 0, 1'b1, 24, 281, 1'b0, "write_hold");
    run_cmd(2'b11, 1'b1, 1'b0, 0, 0, 1'b1, 0, 1, 1'b0, "nop_hold");
    run_cmd(2'b11, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1, 1'b0, "nop");
    run_cmd(2'b01, 1'b0, 1'b0, 0, 0, 1'b0, 240, 281, 1'b0, "write0_after_nop");

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
